// File: rtl/gate_stepper_if.sv
// gate_stepper_if: board controls into the stepper, step index and pulses out
// Ports (master drives controls, slave is the stepper):
//   gate_in   slow gate from the 1 Hz divider
//   run_sw    1 = free-run, 0 = pause
//   step_btn  manual single-step button
//   clr_btn   clear to IDLE / index 0
//   step_idx  current vector index (IDX_W bits)
//   step_tick one-cycle pulse when step_idx changes
//   wrapped   one-cycle pulse when step_idx wraps to 0
//   running   high in RUN
interface gate_stepper_if #(parameter int IDX_W = 4);
  logic gate_in, run_sw, step_btn, clr_btn;
  logic [IDX_W-1:0] step_idx;
  logic step_tick, wrapped, running;
  modport master (output gate_in, run_sw, step_btn, clr_btn, input step_idx, step_tick, wrapped, running);
  modport slave (input gate_in, run_sw, step_btn, clr_btn, output step_idx, step_tick, wrapped, running);
endinterface

// File: rtl/gate_stepper.sv
// gate_stepper: synchronises gate/controls and steps a wrap-around vector index
// Ports: clk, rst_n (async active-low), bus (gate_stepper_if.slave):
//   in  gate_in, run_sw, step_btn, clr_btn
//   out step_idx, step_tick, wrapped, running
// Optional DEBOUNCE_EN: debounces step_btn over DB_CYCLES stable cycles.
module gate_stepper #(
  parameter int NUM_STEPS = 16,
  parameter int IDX_W = 4,
  parameter int DB_CYCLES = 1000000
) (
  input logic clk,
  input logic rst_n,
  gate_stepper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_n;
  logic [2:0] gate_sync;
  logic [1:0] run_sync, clr_sync, btn_sync;
  logic btn_lvl, btn_d;
  logic gate_rise, btn_rise, run_s, clr_s, adv, last;
  logic [IDX_W-1:0] step_idx, idx_n;
  logic step_tick, wrapped;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gate_sync <= '0;
      run_sync <= '0;
      clr_sync <= '0;
      btn_sync <= '0;
      btn_d <= 1'b0;
    end else begin
      gate_sync <= {gate_sync[1:0], bus.gate_in};
      run_sync <= {run_sync[0], bus.run_sw};
      clr_sync <= {clr_sync[0], bus.clr_btn};
      btn_sync <= {btn_sync[0], bus.step_btn};
      btn_d <= btn_lvl;
    end
`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] db_cnt;
  logic db_lvl;
  // counter runs only while the synchronised level disagrees with the debounced one;
  // any return to agreement (a bounce) restarts it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (btn_sync[1] == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= btn_sync[1];
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  assign btn_lvl = db_lvl;
`else
  assign btn_lvl = btn_sync[1];
`endif
  assign gate_rise = gate_sync[1] & ~gate_sync[2];
  assign btn_rise = btn_lvl & ~btn_d;
  assign run_s = run_sync[1];
  assign clr_s = clr_sync[1];
  assign last = step_idx == IDX_W'(NUM_STEPS - 1);
  // clear overrides every other event, including a pending advance
  assign adv = !clr_s && ((state == RUN && gate_rise) || (state == PAUSE && btn_rise));
  always_comb begin
    state_n = state;
    idx_n = step_idx;
    state_n = clr_s ? IDLE : (state == IDLE) ? (run_s ? RUN : IDLE) : (run_s ? RUN : PAUSE);
    idx_n = clr_s ? '0 : adv ? (last ? '0 : step_idx + 1'b1) : step_idx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      step_idx <= '0;
      step_tick <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      state <= state_n;
      step_idx <= idx_n;
      step_tick <= adv;
      wrapped <= adv & last;
    end
  assign bus.step_idx = step_idx;
  assign bus.step_tick = step_tick;
  assign bus.wrapped = wrapped;
  assign bus.running = state == RUN;
endmodule

// File: doc/gate_stepper.md
Name: gate_stepper

Overview:
- Sits directly downstream of the 1 Hz gate divider in the ALU demo.
- Synchronises the slow gate and the board controls, and detects gate rising edges.
- Drives a wrap-around step index that selects the current ALU operand/opcode vector.
- Supports free-run (one step per gate rising edge), pause with manual single-step, and clear.

Parameters:
- NUM_STEPS, 16, number of vectors; step_idx counts 0..NUM_STEPS-1 and wraps; legal range 2..2^IDX_W.
- IDX_W, 4, width of step_idx.
- DB_CYCLES, 1000000, step_btn debounce stable-time in clk cycles (10 ms at 100 MHz); used only with DEBOUNCE_EN.

Ports:
- clk  in  1  system clock (100 MHz board clock).
- rst_n  in  1  asynchronous active-low reset.
- gate_in  in  1  slow gate from the divider (toggles every 0.5 s).
- run_sw  in  1  slide switch; 1 = free-run, 0 = pause.
- step_btn  in  1  push button; each press advances one step while paused.
- clr_btn  in  1  push button; returns to IDLE with step_idx = 0.
- step_idx  out  IDX_W  current vector index.
- step_tick  out  1  one-cycle pulse when step_idx has just changed.
- wrapped  out  1  one-cycle pulse when step_idx has just wrapped NUM_STEPS-1 -> 0.
- running  out  1  high while in RUN state.

Behaviour:
- Reset (rst_n low, asynchronous): all synchroniser and edge flops = 0, state = IDLE, step_idx = 0, step_tick = 0, wrapped = 0, running = 0. Reset asserted mid-step aborts immediately; no tick is emitted on release.
- Synchronisers:
  - gate_in, run_sw, step_btn and clr_btn each pass through a 2-flop synchroniser.
  - gate_in and step_btn also have a third flop for edge detection.
- Edge signals:
  - gate_rise = sync2 & ~sync3.
  - btn_rise is formed the same way on the (debounced) step_btn.
- Latency:
  - step_tick and the new step_idx appear registered in the cycle after the 3rd rising clk edge that samples gate_in (or step_btn) high.
  - run_sw and clr_btn take effect 2 edges after sampling.
- States:
  - IDLE: step_idx held at 0, running = 0. run_s = 1 -> RUN. Otherwise stay.
  - RUN: running = 1. gate_rise -> advance. run_s = 0 -> PAUSE. btn_rise ignored.
  - PAUSE: running = 0. btn_rise -> advance. run_s = 1 -> RUN. gate_rise ignored.
  - clr_s = 1 in any state -> IDLE, step_idx = 0, no tick or wrap pulse. clr_s has priority over every other event.
- Advance:
  - If step_idx == NUM_STEPS-1, step_idx <= 0 and wrapped = 1. Otherwise step_idx <= step_idx + 1.
  - step_tick = 1 for exactly one cycle, coincident with the updated step_idx.
- Simultaneous events:
  - RUN with gate_rise and run_s falling in the same cycle: the advance happens and the next state is PAUSE.
  - PAUSE with btn_rise and run_s rising in the same cycle: the advance happens and the next state is RUN.
- A held step_btn produces exactly one advance per press. A held clr_btn keeps the block in IDLE.
- step_tick and wrapped are never asserted for more than one consecutive cycle.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - The synchronised step_btn feeds a counter.
  - The debounced level changes only after the raw synchronised level has been stable and different from it for DB_CYCLES consecutive cycles.
  - Any bounce restarts the counter.
  - btn_rise is taken from the debounced level, adding DB_CYCLES cycles of latency.
- Undefined:
  - No counter; btn_rise is taken directly from the synchroniser.
  - DB_CYCLES is unused.

Test Plan:
- Reset, then run_sw = 1, 5 gate_in rising edges -> running = 1 within 3 cycles; 5 step_tick pulses, each 1 cycle; step_idx = 5.
- NUM_STEPS = 4, run_sw = 1, 4 gate rises -> step_idx goes 1, 2, 3, 0; wrapped pulses exactly once, coincident with step_idx = 0.
- run_sw = 0 (PAUSE), 3 gate rises, then 2 step_btn presses -> gate ignored; step_idx advances by exactly 2.
- Pulse clr_btn while step_idx = 7 in RUN -> state IDLE, step_idx = 0, no step_tick; with run_sw still 1, return to RUN 1 cycle after clr releases.
- Assert rst_n = 0 asynchronously between clk edges mid-run -> all outputs 0 immediately; no tick after release until a new gate rise.
- With DEBOUNCE_EN and DB_CYCLES = 8, a step_btn bouncing 3 times within 5 cycles, then held 20 cycles -> exactly one advance, about 8 cycles after the final stable edge. Without DEBOUNCE_EN, the same stimulus gives 4 advances.
